// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register, next-PC selection and fetch handshake
// A redirect that cannot be taken because fetch is stalled is held until the next advance.
module pc_fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset_sl2,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             imem_req,
  output logic             fetch_stall,
  output logic             redirect_pending,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT
  } state_t;

  // Instruction addresses are word aligned; low two bits of any target are forced to zero.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state;
  logic [WIDTH-1:0] pending_target;
  logic [WIDTH-1:0] jump_aligned;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] next_pc;
  logic             has_redirect;
  logic             advance;

  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    jump_aligned    = jump_target & ALIGN_MASK;
    branch_target   = pc_plus4 + (branch_offset_sl2 & ALIGN_MASK);
    has_redirect    = jump | branch_taken;
    redirect_target = jump ? jump_aligned : branch_target;
    advance         = (state != ST_BOOT) && imem_ready && en;
    next_pc         = pc_plus4;
    if (has_redirect) begin
      next_pc = redirect_target;
    end else if (redirect_pending) begin
      next_pc = pending_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_BOOT;
      pc               <= RESET_PC;
      imem_req         <= 1'b0;
      fetch_stall      <= 1'b0;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
      fetch_count      <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          imem_req    <= 1'b1;
          fetch_stall <= 1'b0;
        end
        ST_RUN: begin
          if (!imem_ready) begin
            state       <= ST_WAIT;
            fetch_stall <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_ready) begin
            state       <= ST_RUN;
            fetch_stall <= 1'b0;
          end
        end
        default: begin
          state       <= ST_BOOT;
          imem_req    <= 1'b0;
          fetch_stall <= 1'b0;
        end
      endcase

      if (advance) begin
        pc               <= next_pc;
        fetch_count      <= fetch_count + WIDTH'(1);
        redirect_pending <= 1'b0;
      end else if ((state != ST_BOOT) && has_redirect) begin
        // Latest redirect wins while fetch is held.
        pending_target   <= redirect_target;
        redirect_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit against a cycle-level reference model
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        branch_taken;
  logic [15:0] branch_offset_sl2;
  logic        jump;
  logic [15:0] jump_target;
  logic        imem_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus4;
  logic        imem_req;
  logic        fetch_stall;
  logic        redirect_pending;
  logic [15:0] fetch_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: phase 0 = boot, 1 = run, 2 = waiting on memory
  logic [15:0] m_pc;
  logic [15:0] m_tgt;
  logic [15:0] m_count;
  int          m_phase;
  bit          m_pend;

  pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .en(en), .branch_taken(branch_taken),
    .branch_offset_sl2(branch_offset_sl2), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req),
    .fetch_stall(fetch_stall), .redirect_pending(redirect_pending), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic logic [50:0] obs();
    return {pc, pc_plus4, imem_req, fetch_stall, redirect_pending, fetch_count};
  endfunction

  function automatic logic [50:0] expv();
    logic [15:0] p4;
    p4 = 16'((int'(m_pc) + 4) % 65536);
    return {m_pc, p4, m_phase != 0, m_phase == 2, m_pend, m_count};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_tgt = 16'h0000; m_count = 16'h0000; m_phase = 0; m_pend = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit past it.
  task automatic cycle(input logic j, input logic [15:0] jt, input logic b,
                       input logic [15:0] off, input logic e, input logic rdy);
    logic [15:0] tgt;
    bit          live;
    jump = j; jump_target = jt; branch_taken = b; branch_offset_sl2 = off;
    en = e; imem_ready = rdy;
    @(posedge clk);
    live = j || b;
    if (j) tgt = jt & 16'hFFFC;
    else   tgt = 16'((int'(m_pc) + 4 + int'(off & 16'hFFFC)) % 65536);
    if (m_phase == 0) begin
      m_phase = 1;
    end else begin
      if (rdy && e) begin
        if (live)        m_pc = tgt;
        else if (m_pend) m_pc = m_tgt;
        else             m_pc = 16'((int'(m_pc) + 4) % 65536);
        m_count = 16'((int'(m_count) + 1) % 65536);
        m_pend  = 0;
      end else if (live) begin
        m_tgt  = tgt;
        m_pend = 1;
      end
      m_phase = rdy ? 1 : 2;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc[3];
    logic [15:0] exp_cnt[3];
    exp_pc  = '{16'h0000, 16'h0004, 16'h0008};
    exp_cnt = '{16'h0000, 16'h0001, 16'h0002};
    jump = 0; jump_target = 0; branch_taken = 0; branch_offset_sl2 = 0; en = 1; imem_ready = 1;
    reset = 1;
    model_reset();
    #3;
    compared++;
    if (obs() !== expv() || pc !== 16'h0000 || pc_plus4 !== 16'h0004 || imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got %h, want %h", obs(), expv());
    end
    @(negedge clk);
    reset = 0;
    #1;
    compared++;
    if (obs() !== expv() || imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL boot_idle: got %h, want %h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, 0, 16'h0, 1, 1);
      compared++;
      if (obs() !== expv() || pc !== exp_pc[i] || fetch_count !== exp_cnt[i] || imem_req !== 1'b1) begin
        mismatched++;
        $display("FAIL boot_seq[%0d]: got pc=%h cnt=%h req=%b, want pc=%h cnt=%h req=1",
                 i, pc, fetch_count, imem_req, exp_pc[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] want[3];
    want = '{16'h001C, 16'h0020, 16'h0014};
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      cycle(0, 16'h0, 1, 16'h0010, 1, 1);
      else if (i == 1) cycle(0, 16'h0, 0, 16'h0000, 1, 1);
      else             cycle(0, 16'h0, 1, 16'hFFF0, 1, 1);
      compared++;
      if (obs() !== expv() || pc !== want[i]) begin
        mismatched++;
        $display("FAIL branch[%0d]: got pc=%h all=%h, want pc=%h all=%h", i, pc, obs(), want[i], expv());
      end
    end
  endtask

  task automatic test_jump_priority();
    cycle(1, 16'h0040, 0, 16'h0000, 1, 1);
    cycle(1, 16'h1237, 1, 16'h0100, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h1234) begin
      mismatched++;
      $display("FAIL jump_priority: got pc=%h, want pc=1234", pc);
    end
  endtask

  task automatic test_stall_redirect();
    cycle(1, 16'h0010, 0, 16'h0000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, (i == 0), 16'h0020, 1, 0);
      compared++;
      if (obs() !== expv() || pc !== 16'h0010 || fetch_stall !== 1'b1 || redirect_pending !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got pc=%h stall=%b pend=%b, want pc=0010 stall=1 pend=1",
                 i, pc, fetch_stall, redirect_pending);
      end
    end
    cycle(0, 16'h0, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0034 || redirect_pending !== 1'b0 || fetch_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_release: got pc=%h pend=%b stall=%b, want pc=0034 pend=0 stall=0",
               pc, redirect_pending, fetch_stall);
    end
    // en low holds the PC; the second redirect replaces the first.
    cycle(0, 16'h0, 1, 16'h0008, 0, 1);
    cycle(1, 16'h0100, 0, 16'h0000, 0, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0034 || redirect_pending !== 1'b1 || fetch_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL en_hold: got pc=%h pend=%b stall=%b, want pc=0034 pend=1 stall=0",
               pc, redirect_pending, fetch_stall);
    end
    cycle(0, 16'h0, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0100) begin
      mismatched++;
      $display("FAIL latest_wins: got pc=%h, want pc=0100", pc);
    end
  endtask

  task automatic test_pc_wrap();
    cycle(1, 16'hFFFC, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'hFFFC || pc_plus4 !== 16'h0000) begin
      mismatched++;
      $display("FAIL pc_top: got pc=%h p4=%h, want pc=fffc p4=0000", pc, pc_plus4);
    end
    cycle(0, 16'h0, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0000) begin
      mismatched++;
      $display("FAIL pc_wrap: got pc=%h, want pc=0000", pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 3) == 0, 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h, want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_count_wrap();
    int guard;
    guard = 0;
    while (m_count != 16'hFFFF && guard < 70000) begin
      cycle(0, 16'h0, 0, 16'h0000, 1, 1);
      guard++;
    end
    compared++;
    if (obs() !== expv() || fetch_count !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL count_top: got cnt=%h, want cnt=ffff", fetch_count);
    end
    cycle(0, 16'h0, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || fetch_count !== 16'h0000) begin
      mismatched++;
      $display("FAIL count_wrap: got cnt=%h, want cnt=0000", fetch_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    cycle(0, 16'h0, 1, 16'h0040, 1, 0);
    compared++;
    if (obs() !== expv() || fetch_stall !== 1'b1 || redirect_pending !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_wait: got stall=%b pend=%b, want stall=1 pend=1", fetch_stall, redirect_pending);
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    compared++;
    if (obs() !== expv() || pc !== 16'h0000 || imem_req !== 1'b0 || redirect_pending !== 1'b0
        || fetch_count !== 16'h0000 || fetch_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got %h, want %h", obs(), expv());
    end
    @(negedge clk);
    reset = 0;
    cycle(0, 16'h0, 1, 16'h0040, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0000 || imem_req !== 1'b1 || redirect_pending !== 1'b0) begin
      mismatched++;
      $display("FAIL reboot: got pc=%h req=%b pend=%b, want pc=0000 req=1 pend=0", pc, imem_req, redirect_pending);
    end
    cycle(0, 16'h0, 0, 16'h0000, 1, 1);
    compared++;
    if (obs() !== expv() || pc !== 16'h0004 || fetch_count !== 16'h0001) begin
      mismatched++;
      $display("FAIL reboot_run: got pc=%h cnt=%h, want pc=0004 cnt=0001", pc, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall_redirect();
    test_pc_wrap();
    test_random();
    test_count_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
